// File: rtl/grad_spi_serializer.sv
// SPI serializer feeding four gradient DACs: shifts 24-bit payloads MSB-first (mode 0)
// with per-channel chip selects and a one-word pending buffer for words arriving mid-frame.
module grad_spi_serializer #(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        sclk_o,
  output logic        sdo_o,
  output logic [3:0]  cs_n_o
);

  localparam int unsigned HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t      state;
  logic [HW-1:0] hcnt;
  logic [GW-1:0] gcnt;
  logic [4:0]  bit_cnt;
  logic [22:0] shreg;
  logic [25:0] pend;
  logic        pend_v;

  logic        gap_last;
  logic        load_now;
  logic [25:0] load_word;
  logic        unused_hi;

  assign unused_hi = ^data_i[31:26];

  // A frame starts from IDLE on a strobe, or back-to-back from the last GAP cycle,
  // where the pending word has priority over a word arriving that same cycle.
  always_comb begin
    gap_last  = (state == GAP) && (gcnt == G_LAST);
    load_now  = ((state == IDLE) && valid_i) || (gap_last && (pend_v || valid_i));
    load_word = (gap_last && pend_v) ? pend : data_i[25:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      gcnt       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
      sclk_o     <= 1'b0;
      sdo_o      <= 1'b0;
      cs_n_o     <= '1;
    end else begin
      case (state)
        IDLE: ;
        SETUP: begin
          if (hcnt == H_LAST) begin
            hcnt   <= '0;
            sclk_o <= 1'b1;
            state  <= SHIFT;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        SHIFT: begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (sclk_o) begin
              sclk_o <= 1'b0;
              sdo_o  <= shreg[22];
              shreg  <= {shreg[21:0], 1'b0};
            end else if (bit_cnt == 5'd23) begin
              state  <= GAP;
              gcnt   <= '0;
              cs_n_o <= '1;
              sdo_o  <= 1'b0;
            end else begin
              sclk_o  <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Overrides the GAP->IDLE exit when another word is ready.
      if (load_now) begin
        state   <= SETUP;
        busy_o  <= 1'b1;
        hcnt    <= '0;
        bit_cnt <= '0;
        sclk_o  <= 1'b0;
        sdo_o   <= load_word[23];
        shreg   <= load_word[22:0];
        cs_n_o  <= ~(4'b0001 << load_word[25:24]);
      end

      if ((state != IDLE) && valid_i) begin
        if (gap_last && pend_v) begin
          pend <= data_i[25:0];
        end else if (!gap_last) begin
          if (!pend_v) begin
            pend   <= data_i[25:0];
            pend_v <= 1'b1;
          end else begin
            overflow_o <= 1'b1;
          end
        end
      end else if (gap_last && pend_v) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule
